mac_result_buffer: RTL and testbench

MAC_RESULT_BUFFER -- requirements
Module: mac_result_buffer

---
 rtl/mac_result_buffer.sv | 124 ++++++++++++
 tb/tb_mac_result_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mac_result_buffer.sv
// ----------------------------------------------------------------------------
// mac_result_buffer
//   Small show-ahead FIFO that captures results from a MAC unit that cannot be
//   stalled. A result arriving while the buffer is full, with no pop in the
//   same cycle, is dropped. Each drop sets a sticky overflow flag and bumps a
//   saturating drop counter. The head entry is driven combinationally from
//   storage, so a result pushed into an empty buffer is visible on the cycle
//   right after its edge.
//
// Parameters
//   DEPTH : number of entries (power of two, 2..16)
//   CW    : width of the saturating drop counter
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (control state only)
//   valido    : upstream result valid, one pulse per result
//   data_out  : upstream result value
//   clr       : synchronous flush of entries and status
//   res_ready : downstream consumer ready
//   res_valid : head entry present
//   res_data  : head entry value (don't-care while res_valid=0)
//   count     : number of stored entries
//   full      : count == DEPTH
//   overflow  : sticky, a result was dropped
//   drop_cnt  : number of dropped results, saturating
// ----------------------------------------------------------------------------
module mac_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valido,
  input  logic [31:0]              data_out,
  input  logic                     clr,
  input  logic                     res_ready,
  output logic                     res_valid,
  output logic [31:0]              res_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [CW-1:0]            drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

  logic pop;
  logic push;
  logic drop;

  assign res_valid = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign res_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    pop  = res_valid && res_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push = valido && (!full || pop) && !clr;
    // clr discards the incoming result without counting it as a drop.
    drop = valido && full && !pop && !clr;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_out;
  end

endmodule

// File: tb/tb_mac_result_buffer.sv
module tb_mac_result_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   valido;
  logic [31:0]            data_out;
  logic                   clr;
  logic                   res_ready;
  logic                   res_valid;
  logic [31:0]            res_data;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   overflow;
  logic [CW-1:0]          drop_cnt;

  mac_result_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valido    (valido),
    .data_out  (data_out),
    .clr       (clr),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        c;
    logic        r;
    logic        e_vld;
    logic [31:0] e_data;
    int          e_cnt;
    logic        e_full;
    logic        e_ovf;
    int          e_drop;
  } vec_t;

  vec_t tbl [96];
  int   n      = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d, input logic c,
                     input logic r, input logic e_vld, input logic [31:0] e_data,
                     input int e_cnt, input logic e_full, input logic e_ovf,
                     input int e_drop);
    tbl[n].v      = v;
    tbl[n].d      = d;
    tbl[n].c      = c;
    tbl[n].r      = r;
    tbl[n].e_vld  = e_vld;
    tbl[n].e_data = e_data;
    tbl[n].e_cnt  = e_cnt;
    tbl[n].e_full = e_full;
    tbl[n].e_ovf  = e_ovf;
    tbl[n].e_drop = e_drop;
    n++;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic c,
                       input logic r);
    @(negedge clk);
    valido    = v;
    data_out  = d;
    clr       = c;
    res_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    valido    = 1'b0;
    data_out  = '0;
    clr       = 1'b0;
    res_ready = 1'b0;

    // Single result, then consume it.
    add(1, 32'h7, 0, 0,  1, 32'h7, 1, 0, 0, 0);
    add(0, 32'h0, 0, 1,  0, 32'h0, 0, 0, 0, 0);
    // Fill with 1..4, drop 5 and 6, drain in order.
    add(1, 32'd1, 0, 0,  1, 32'd1, 1, 0, 0, 0);
    add(1, 32'd2, 0, 0,  1, 32'd1, 2, 0, 0, 0);
    add(1, 32'd3, 0, 0,  1, 32'd1, 3, 0, 0, 0);
    add(1, 32'd4, 0, 0,  1, 32'd1, 4, 1, 0, 0);
    add(1, 32'd5, 0, 0,  1, 32'd1, 4, 1, 1, 1);
    add(1, 32'd6, 0, 0,  1, 32'd1, 4, 1, 1, 2);
    add(0, 32'd0, 0, 1,  1, 32'd2, 3, 0, 1, 2);
    add(0, 32'd0, 0, 1,  1, 32'd3, 2, 0, 1, 2);
    add(0, 32'd0, 0, 1,  1, 32'd4, 1, 0, 1, 2);
    add(0, 32'd0, 0, 1,  0, 32'd0, 0, 0, 1, 2);
    // clr wipes sticky status.
    add(0, 32'd0, 1, 0,  0, 32'd0, 0, 0, 0, 0);
    // Full with simultaneous pop accepts the new result.
    add(1, 32'd10, 0, 0, 1, 32'd10, 1, 0, 0, 0);
    add(1, 32'd11, 0, 0, 1, 32'd10, 2, 0, 0, 0);
    add(1, 32'd12, 0, 0, 1, 32'd10, 3, 0, 0, 0);
    add(1, 32'd13, 0, 0, 1, 32'd10, 4, 1, 0, 0);
    add(1, 32'd14, 0, 1, 1, 32'd11, 4, 1, 0, 0);
    add(0, 32'd0, 0, 1,  1, 32'd12, 3, 0, 0, 0);
    add(0, 32'd0, 0, 1,  1, 32'd13, 2, 0, 0, 0);
    add(0, 32'd0, 0, 1,  1, 32'd14, 1, 0, 0, 0);
    add(0, 32'd0, 0, 1,  0, 32'd0, 0, 0, 0, 0);
    // Drop counter saturates at 3 with CW=2.
    add(1, 32'd20, 0, 0, 1, 32'd20, 1, 0, 0, 0);
    add(1, 32'd21, 0, 0, 1, 32'd20, 2, 0, 0, 0);
    add(1, 32'd22, 0, 0, 1, 32'd20, 3, 0, 0, 0);
    add(1, 32'd23, 0, 0, 1, 32'd20, 4, 1, 0, 0);
    add(1, 32'd30, 0, 0, 1, 32'd20, 4, 1, 1, 1);
    add(1, 32'd31, 0, 0, 1, 32'd20, 4, 1, 1, 2);
    add(1, 32'd32, 0, 0, 1, 32'd20, 4, 1, 1, 3);
    add(1, 32'd33, 0, 0, 1, 32'd20, 4, 1, 1, 3);
    add(1, 32'd34, 0, 0, 1, 32'd20, 4, 1, 1, 3);
    // clr beats a simultaneous valido; nothing stored, no drop counted.
    add(1, 32'd99, 1, 0, 0, 32'd0, 0, 0, 0, 0);
    add(0, 32'd0, 0, 0,  0, 32'd0, 0, 0, 0, 0);
    // Empty buffer ignores res_ready.
    add(0, 32'd0, 0, 1,  0, 32'd0, 0, 0, 0, 0);
    add(1, 32'h55, 0, 1, 1, 32'h55, 1, 0, 0, 0);
    add(0, 32'd0, 0, 0,  1, 32'h55, 1, 0, 0, 0);
    add(0, 32'd0, 0, 1,  0, 32'd0, 0, 0, 0, 0);
    // Wrap-around: push and pop every cycle, pointers lap several times.
    for (int k = 0; k < 10; k++)
      add(1, 32'(k), 0, 1, 1, 32'(k), 1, 0, 0, 0);
    add(0, 32'd0, 0, 1,  0, 32'd0, 0, 0, 0, 0);

    // Reset state.
    #12;
    chk("rst_valid", -1, 32'(res_valid), 32'd0);
    chk("rst_count", -1, 32'(count),     32'd0);
    chk("rst_full",  -1, 32'(full),      32'd0);
    chk("rst_ovf",   -1, 32'(overflow),  32'd0);
    chk("rst_drop",  -1, 32'(drop_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < n; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
      chk("res_valid", i, 32'(res_valid), 32'(tbl[i].e_vld));
      chk("count",     i, 32'(count),     32'(tbl[i].e_cnt));
      chk("full",      i, 32'(full),      32'(tbl[i].e_full));
      chk("overflow",  i, 32'(overflow),  32'(tbl[i].e_ovf));
      chk("drop_cnt",  i, 32'(drop_cnt),  32'(tbl[i].e_drop));
      if (tbl[i].e_vld)
        chk("res_data", i, res_data, tbl[i].e_data);
    end

    // Asynchronous reset mid-operation with 3 stored entries.
    drive(1, 32'hA1, 0, 0);
    drive(1, 32'hA2, 0, 0);
    drive(1, 32'hA3, 0, 0);
    chk("pre_rst_count", 200, 32'(count), 32'd3);
    @(negedge clk);
    valido = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 201, 32'(count),     32'd0);
    chk("async_valid", 201, 32'(res_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'hFFFF_FFFF, 0, 0);
    chk("post_rst_count", 202, 32'(count),     32'd1);
    chk("post_rst_valid", 202, 32'(res_valid), 32'd1);
    chk("post_rst_data",  202, res_data,       32'hFFFF_FFFF);
    drive(0, 32'd0, 0, 1);
    chk("post_rst_drain", 203, 32'(count),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
